// File: rtl/latch_write_arbiter.sv
// Round-robin write controller for a bank of transparent latches on one shared bus.
// Each accepted write runs SETUP -> OPEN -> CLOSE so data is stable around the gate window.
module latch_write_arbiter #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int NREQ        = 2,
  parameter int AW          = 2,
  parameter int OPEN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [WIDTH-1:0]      bus_data,
  output logic [DEPTH-1:0]      latch_gate
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_d, done_d;
  logic              err_d, busy_d;
  logic [WIDTH-1:0]  bus_d;
  logic [DEPTH-1:0]  gate_d;

  logic [PW-1:0]     pick;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              addr_ok;
  logic [DEPTH-1:0]  target_gate;

  // Lowest offset from p (wrapping) among the asserted requests wins.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] idx;
    rr_pick = p;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(p) + i) % NREQ);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick        = rr_pick(req, ptr_q);
  assign sel_addr    = AW'(req_addr >> (int'(pick) * AW));
  assign sel_data    = WIDTH'(req_data >> (int'(pick) * WIDTH));
  assign addr_ok     = int'(sel_addr) < DEPTH;
  assign target_gate = ~(DEPTH'(1) << addr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      bus_data   <= '0;
      latch_gate <= '1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      gnt        <= gnt_d;
      done       <= done_d;
      err        <= err_d;
      busy       <= busy_d;
      bus_data   <= bus_d;
      latch_gate <= gate_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = busy;
    bus_d   = bus_data;
    gate_d  = '1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          win_d = pick;
          ptr_d = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
          gnt_d = NREQ'(1) << pick;
          // Out-of-range targets are acknowledged and dropped without touching the bus.
          if (addr_ok) begin
            addr_d  = sel_addr;
            bus_d   = sel_data;
            busy_d  = 1'b1;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CW'(OPEN_CYCLES - 1);
        gate_d  = target_gate;
      end
      OPEN: begin
        if (cnt_q == '0) begin
          state_d = CLOSE;
          done_d  = NREQ'(1) << win_q;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          gate_d = target_gate;
        end
      end
      CLOSE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: transaction-timeline reference model plus a behavioural latch bank.
module tb_latch_write_arbiter;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int N  = 2;
  localparam int A  = 2;
  localparam int OC = 2;
  localparam int VW = 2 * N + 2 + W + D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*A-1:0] req_addr = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt, done;
  logic           err, busy;
  logic [W-1:0]   bus_data;
  logic [D-1:0]   latch_gate;

  always #5 clk = ~clk;

  latch_write_arbiter #(.WIDTH(W), .DEPTH(D), .NREQ(N), .AW(A), .OPEN_CYCLES(OC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .bus_data(bus_data), .latch_gate(latch_gate)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural latch bank driven by the DUT outputs.
  logic [W-1:0] lat [D] = '{default: '0};
  always @(bus_data or latch_gate)
    for (int i = 0; i < D; i++)
      if (((latch_gate >> i) & 1) == 0) lat[i] = bus_data;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(~latch_gate)) begin
      failures++;
      $display("FAIL one_gate latch_gate=%b required at most one low bit", latch_gate);
    end
  end

  // Reference model: a write accepted at edge m_start defines the whole output timeline.
  int e = 0;
  int m_start = -100;
  int m_win = 0;
  int m_addr = 0;
  int m_ptr = 0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] p_gnt = '0;
  logic         p_err = 1'b0;
  logic [W-1:0] mem [D] = '{default: '0};
  bit           known [D] = '{default: 1'b1};
  logic [VW-1:0] exp_vec;
  logic          exp_busy;
  logic [VW-1:0] obs_vec;
  assign obs_vec = {gnt, done, err, busy, bus_data, latch_gate};

  function automatic void build();
    int k;
    logic [D-1:0] g;
    logic [N-1:0] dn;
    k = e - m_start + 1;
    exp_busy = (k >= 1) && (k <= 2 + OC);
    g  = ((k >= 2) && (k <= 1 + OC)) ? ~(D'(1) << m_addr) : '1;
    dn = (k == 2 + OC) ? (N'(1) << m_win) : '0;
    exp_vec = {p_gnt, dn, p_err, exp_busy, m_data, g};
  endfunction

  function automatic void model_reset();
    int k;
    k = e - m_start + 1;
    if ((k >= 2) && (k <= 1 + OC)) known[m_addr] = 1'b0;
    m_ptr = 0; m_start = -100; m_data = '0; p_gnt = '0; p_err = 1'b0;
    build();
  endfunction

  function automatic void model_edge();
    int w, a, idx;
    e++;
    p_gnt = '0;
    p_err = 1'b0;
    if ((e >= m_start + 3 + OC) && (req != '0)) begin
      w = -1;
      for (int off = 0; off < N; off++) begin
        idx = (m_ptr + off) % N;
        if (w < 0 && ((req >> idx) & 1) != 0) w = idx;
      end
      a = int'(A'(req_addr >> (w * A)));
      m_ptr = (w + 1) % N;
      p_gnt = N'(1) << w;
      if (a < D) begin
        m_start = e; m_win = w; m_addr = a;
        m_data = W'(req_data >> (w * W));
      end else begin
        p_err = 1'b1;
      end
    end
    if (e - m_start + 1 == 2 + OC) begin
      mem[m_addr] = m_data;
      known[m_addr] = 1'b1;
    end
    build();
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_reset();
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      req = N'($urandom); req_addr = (N*A)'($urandom); req_data = (N*W)'($urandom);
      step();
      checks++;
      if (obs_vec !== {{(2*N+2+W){1'b0}}, {D{1'b1}}}) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%h want=%h", c, obs_vec, {{(2*N+2+W){1'b0}}, {D{1'b1}}});
      end
    end
    req = '0;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL reset_quiet cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_write();
    req = 2'b01; req_addr = {2'd0, 2'd2}; req_data = {8'h00, 8'hA5};
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req = '0;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL single_model cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
      if (busy !== (c <= 4)) begin
        failures++;
        $display("FAIL single_busy cyc%0d got=%b want=%b", c, busy, (c <= 4));
      end
      if (c == 1) begin
        checks++;
        if (gnt !== 2'b01 || bus_data !== 8'hA5) begin
          failures++;
          $display("FAIL single_gnt got gnt=%b bus=%h want gnt=01 bus=a5", gnt, bus_data);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (latch_gate !== 3'b011) begin
          failures++;
          $display("FAIL single_gate cyc%0d got=%b want=011", c, latch_gate);
        end
      end
      if (c == 4) begin
        checks++;
        if (done !== 2'b01 || lat[2] !== 8'hA5) begin
          failures++;
          $display("FAIL single_done got done=%b latch=%h want done=01 latch=a5", done, lat[2]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int gcyc [$];
    logic [N-1:0] gseq [$];
    do_reset(2);
    req = 2'b11; req_addr = {2'd1, 2'd0}; req_data = {8'h3C, 8'hC3};
    for (int c = 1; c <= 22; c++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL fair_model cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (gnt != '0) begin gcyc.push_back(c); gseq.push_back(gnt); end
    end
    req = '0;
    repeat (6) step();
    checks++;
    if (gseq.size() < 4) begin
      failures++;
      $display("FAIL fair_count got=%0d want>=4", gseq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gseq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || gcyc[i] != 1 + 5 * i) begin
          failures++;
          $display("FAIL fair_seq #%0d got gnt=%b cyc=%0d want gnt=%b cyc=%0d",
                   i, gseq[i], gcyc[i], (i % 2 == 0) ? 2'b01 : 2'b10, 1 + 5 * i);
        end
      end
    end
    checks++;
    if (lat[0] !== 8'hC3 || lat[1] !== 8'h3C) begin
      failures++;
      $display("FAIL fair_latch got l0=%h l1=%h want l0=c3 l1=3c", lat[0], lat[1]);
    end
  endtask

  task automatic test_bad_addr();
    do_reset(1);
    req = 2'b11; req_addr = {2'd1, 2'd3}; req_data = {8'h5A, 8'h77};
    step();
    req = 2'b10;
    checks++;
    if (gnt !== 2'b01 || err !== 1'b1 || busy !== 1'b0 || latch_gate !== 3'b111) begin
      failures++;
      $display("FAIL bad_err got gnt=%b err=%b busy=%b gate=%b want 01 1 0 111", gnt, err, busy, latch_gate);
    end
    step();
    req = '0;
    checks++;
    if (gnt !== 2'b10 || err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bad_next got gnt=%b err=%b busy=%b want 10 0 1", gnt, err, busy);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL bad_model cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    if (lat[1] !== 8'h5A) begin
      failures++;
      $display("FAIL bad_latch got=%h want=5a", lat[1]);
    end
  endtask

  task automatic test_reset_mid_open();
    bit seen;
    req = 2'b01; req_addr = {2'd0, 2'd1}; req_data = {8'h00, 8'h99};
    step();
    req = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL mid_model cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      if (latch_gate[1] === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_wait gate1 never low within 10 cycles");
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (latch_gate !== 3'b111 || busy !== 1'b0 || obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL mid_async got gate=%b busy=%b want gate=111 busy=0", latch_gate, busy);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL mid_hold cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    reset = 1'b0;
    req = 2'b11; req_addr = {2'd2, 2'd0}; req_data = {8'h4B, 8'hB4};
    step();
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL mid_first got gnt=%b want=01", gnt);
    end
    for (int c = 0; c < 12; c++) begin
      req = req & ~gnt;
      step();
      checks++;
      if (obs_vec !== exp_vec || done !== exp_vec[VW-N-1 -: N]) begin
        failures++;
        $display("FAIL mid_after cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    req = '0;
  endtask

  task automatic test_data_stability();
    req = 2'b01; req_addr = {2'd0, 2'd0}; req_data = {8'h00, 8'hE1};
    step();
    req = '0;
    for (int c = 0; c < 6; c++) begin
      req_data = (N*W)'($urandom); req_addr = (N*A)'($urandom);
      step();
      checks++;
      if (obs_vec !== exp_vec || (exp_busy && bus_data !== 8'hE1)) begin
        failures++;
        $display("FAIL stable cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    if (lat[0] !== 8'hE1) begin
      failures++;
      $display("FAIL stable_latch got=%h want=e1", lat[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req = req & ~gnt;
      for (int i = 0; i < N; i++) begin
        if (((req >> i) & 1) == 0) begin
          req_data[i*W +: W] = W'($urandom);
          req_addr[i*A +: A] = A'($urandom);
          if ($urandom_range(0, 3) == 0) req = req | (N'(1) << i);
        end
      end
      step();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random cyc%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
    end
    req = '0;
    repeat (8) step();
    for (int i = 0; i < D; i++) begin
      if (known[i]) begin
        checks++;
        if (lat[i] !== mem[i]) begin
          failures++;
          $display("FAIL random_latch%0d got=%h want=%h", i, lat[i], mem[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_write();
    test_fairness();
    test_bad_addr();
    test_reset_mid_open();
    test_data_stability();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
